// File: rtl/edge_event_capture.sv
// Multi-channel edge event capture.
// Each channel has an optional synchroniser, a debounce filter, mode-selected
// edge events, a single-cycle pulse, and sticky pending and overflow flags
// that are cleared by writing 1 to clr. irq is the OR of all pending flags.
module edge_event_capture #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 anrst,
  input  logic [WIDTH-1:0]     in,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     clr,
  output logic [WIDTH-1:0]     filt,
  output logic [WIDTH-1:0]     pulse,
  output logic [WIDTH-1:0]     pending,
  output logic [WIDTH-1:0]     overflow,
  output logic                 irq
);

  localparam int            CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] FC = CW'(FILTER_CYCLES);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] ev;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [CW-1:0]    cnt_inc;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      // Synchroniser shift chain; the last stage feeds the filter
      always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
          for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= in;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Debounce counters and edge detection on the next filtered level
  always_comb begin
    filt_d  = filt;
    ev      = '0;
    cnt_inc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      cnt_inc  = cnt_q[i] + 1'b1;
      if (s[i] != filt[i]) begin
        if (cnt_inc == FC) filt_d[i] = s[i];
        else               cnt_d[i]  = cnt_inc;
      end
      ev[i] = (mode[2*i]   &  filt_d[i] & ~filt[i]) |
              (mode[2*i+1] & ~filt_d[i] &  filt[i]);
    end
  end

  // Filter state, event strobe and sticky flags; events win over clr
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      filt     <= '0;
      pulse    <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      filt     <= filt_d;
      pulse    <= ev;
      pending  <= (pending & ~clr) | ev;
      overflow <= (overflow & ~clr) | (ev & pending & ~clr);
    end
  end

  assign irq = |pending;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed, table-driven bench for edge_event_capture (4 channels, 2 sync, filter 3).
module tb_edge_event_capture;

  logic       clk = 1'b0;
  logic       anrst;
  logic [3:0] din;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] filt, pulse, pending, overflow;
  logic       irq;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  edge_event_capture #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .FILTER_CYCLES(3)
  ) dut (
    .clk(clk),
    .anrst(anrst),
    .in(din),
    .mode(mode),
    .clr(clr),
    .filt(filt),
    .pulse(pulse),
    .pending(pending),
    .overflow(overflow),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic [7:0] mode;
    logic [3:0] clr;
    int         ncyc;
    logic [3:0] filt;
    logic [3:0] pulse;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic       irq;
  } vec_t;

  localparam int NV = 37;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [3:0] d, input logic [7:0] m, input logic [3:0] c,
                              input int n, input logic [3:0] f, input logic [3:0] p,
                              input logic [3:0] pe, input logic [3:0] o, input logic q);
    vec_t v;
    v.din = d; v.mode = m; v.clr = c; v.ncyc = n;
    v.filt = f; v.pulse = p; v.pend = pe; v.ovf = o; v.irq = q;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
  endtask

  task automatic check_all(input int idx, input logic [3:0] f, input logic [3:0] p,
                           input logic [3:0] pe, input logic [3:0] o, input logic q);
    check("filt",     idx, filt,            f);
    check("pulse",    idx, pulse,           p);
    check("pending",  idx, pending,         pe);
    check("overflow", idx, overflow,        o);
    check("irq",      idx, {3'b000, irq},   {3'b000, q});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // step rise on ch0, rising mode
    vt[0]  = mk(4'b0001, 8'h01, 4'b0000, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[1]  = mk(4'b0001, 8'h01, 4'b0000, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    vt[2]  = mk(4'b0001, 8'h01, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    vt[3]  = mk(4'b0001, 8'h01, 4'b0000, 5, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    vt[4]  = mk(4'b0001, 8'h01, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[5]  = mk(4'b0001, 8'h01, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // 2-clock glitch on ch1 rejected, then 3-clock pulse accepted
    vt[6]  = mk(4'b0011, 8'h0C, 4'b0000, 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[7]  = mk(4'b0001, 8'h0C, 4'b0000, 6, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[8]  = mk(4'b0011, 8'h0C, 4'b0000, 3, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[9]  = mk(4'b0001, 8'h0C, 4'b0000, 2, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 1'b1);
    vt[10] = mk(4'b0001, 8'h0C, 4'b0000, 3, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 1'b1);
    vt[11] = mk(4'b0001, 8'h0C, 4'b0010, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // falling-only on ch2
    vt[12] = mk(4'b0101, 8'h20, 4'b0000, 5, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[13] = mk(4'b0101, 8'h20, 4'b0000, 5, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[14] = mk(4'b0001, 8'h20, 4'b0000, 4, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[15] = mk(4'b0001, 8'h20, 4'b0000, 1, 4'b0001, 4'b0100, 4'b0100, 4'b0000, 1'b1);
    vt[16] = mk(4'b0001, 8'h20, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 1'b1);
    vt[17] = mk(4'b0001, 8'h20, 4'b0100, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // clear / overflow on ch0
    vt[18] = mk(4'b0000, 8'h01, 4'b0000, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[19] = mk(4'b0001, 8'h01, 4'b0000, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[20] = mk(4'b0001, 8'h01, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    vt[21] = mk(4'b0000, 8'h01, 4'b0000, 5, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    vt[22] = mk(4'b0001, 8'h01, 4'b0000, 5, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1);
    vt[23] = mk(4'b0001, 8'h01, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // event coinciding with clr of an old pending: no overflow
    vt[24] = mk(4'b0000, 8'h01, 4'b0000, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[25] = mk(4'b0001, 8'h01, 4'b0000, 5, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    vt[26] = mk(4'b0000, 8'h01, 4'b0000, 5, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    vt[27] = mk(4'b0001, 8'h01, 4'b0000, 4, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    vt[28] = mk(4'b0001, 8'h01, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    vt[29] = mk(4'b0001, 8'h01, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // mode off: filt tracks, no events
    vt[30] = mk(4'b1110, 8'h00, 4'b0000, 4, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[31] = mk(4'b1110, 8'h00, 4'b0000, 1, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[32] = mk(4'b0001, 8'h00, 4'b0000, 5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[33] = mk(4'b1111, 8'h00, 4'b0000, 5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // set up all-pending with a filter mid-count
    vt[34] = mk(4'b0000, 8'h55, 4'b0000, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    vt[35] = mk(4'b1111, 8'h55, 4'b0000, 5, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b1);
    vt[36] = mk(4'b0000, 8'h55, 4'b0000, 3, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b1);

    anrst = 1'b0;
    din   = '0;
    mode  = '0;
    clr   = '0;
    step(2);
    check_all(-1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    anrst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      din  = vt[i].din;
      mode = vt[i].mode;
      clr  = vt[i].clr;
      step(vt[i].ncyc);
      check_all(i, vt[i].filt, vt[i].pulse, vt[i].pend, vt[i].ovf, vt[i].irq);
    end

    // asynchronous reset while a filter counter is running and all pending set
    #2 anrst = 1'b0;
    #1 check_all(100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    din  = 4'b1111;
    mode = 8'h55;
    clr  = '0;
    step(1);
    anrst = 1'b1;
    step(4);
    check_all(101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1);
    check_all(102, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b1);
    step(1);
    check_all(103, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_event_capture.md
Name: edge_event_capture

Overview:
- Multi-channel edge event unit: the next generation of the single-stage edge detector.
- Per channel it provides an optional input synchroniser, a glitch (debounce) filter, per-channel edge-mode selection, single-cycle event pulses, sticky pending flags with write-1-to-clear, and overflow detection.
- A combined interrupt line is produced.
- Sits between asynchronous/noisy inputs (buttons, external status pins) and control logic or CSR blocks.

Parameters:
- WIDTH, 8, number of independent channels (1..64).
- SYNC_STAGES, 2, synchroniser flops per channel (0 = input already synchronous, 1..4 otherwise).
- FILTER_CYCLES, 4, consecutive clocks a new level must persist before it is accepted (1..255; 1 = no filtering).

Ports:
- clk  in  1  clock
- anrst  in  1  reset
- in  in  WIDTH  raw channel inputs
- mode  in  2*WIDTH  per channel ch, bits [2ch+1:2ch]: 00 off, 01 rising, 10 falling, 11 both
- clr  in  WIDTH  write-1-to-clear, sampled each clock, for pending and overflow
- filt  out  WIDTH  filtered (debounced) level
- pulse  out  WIDTH  one-clock event strobe, already masked by mode
- pending  out  WIDTH  sticky event flags
- overflow  out  WIDTH  sticky flag: event arrived while pending was already set
- irq  out  1  OR of all pending bits

Interface (decided): one clock, clk; reset anrst is asynchronous and active-low.

Behaviour:
- Reset (anrst low, asynchronous, any time, including mid-filter):
  - Sync chain, filter counters, filt, pulse, pending and overflow all go to 0 immediately.
  - irq goes to 0.
- Synchroniser:
  - SYNC_STAGES flops per channel, all reset to 0; s = last stage.
  - With SYNC_STAGES=0, s = in directly.
- Filter, per channel:
  - Counter cnt, width clog2(FILTER_CYCLES+1).
  - If s == filt: cnt <= 0.
  - Else: cnt <= cnt+1. When cnt+1 == FILTER_CYCLES, filt <= s and cnt <= 0 on that edge.
  - A glitch shorter than FILTER_CYCLES clocks at s produces no change.
  - Latency from an input change to a filt change: exactly SYNC_STAGES+FILTER_CYCLES clocks for a clean step.
- Event, per channel:
  - rise = filt_next & ~filt; fall = ~filt_next & filt.
  - ev = (mode[0] & rise) | (mode[1] & fall).
  - pulse <= ev. pulse is registered and high for exactly one clock, coincident with the first cycle of the new filt value.
  - With mode 00 the channel still filters and filt still tracks, but pulse, pending and overflow never set.
  - A mode change takes effect from the next clock edge. It does not clear pending.
- Pending / overflow, per channel, registered on the same edge as pulse:
  - pending <= (pending & ~clr) | ev. An event wins over a simultaneous clr.
  - overflow <= (overflow & ~clr) | (ev & pending & ~clr).
  - An event arriving while clr clears the old pending does not count as overflow.
- irq = |pending, combinational from the registers; no extra latency.
- After reset release:
  - filt starts at 0.
  - An input held high produces a rising event after SYNC_STAGES+FILTER_CYCLES clocks. This is intended.
- Toggle faster than FILTER_CYCLES: filt holds and no events are generated.
- Toggle slower: every accepted level change generates at most one pulse.

Test Plan (WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=3):
1. Step, rising mode: mode=8'h01, in[0] 0->1 held.
   - filt[0]=1 and pulse[0]=1 exactly 5 clocks after the change; pulse lasts 1 clock.
   - pending[0]=1 and irq=1 in the same cycle as pulse, and remain until cleared.
2. Glitch rejection: mode=8'h0C, in[1] high for 2 clocks -> filt[1], pulse[1] and pending[1] stay 0.
   - Repeat with a 3-clock pulse: filt[1] rises after 5 clocks, falls 3 clocks later, and pulse[1] fires twice.
3. Falling-only: mode=8'h20, in[2] 0->1 (held 10 clocks) ->0.
   - No pulse on the rise; a single pulse[2] 5 clocks after the fall.
4. Clear and overflow on channel 0, mode 01:
   - Event with clr[0]=1 in the same cycle -> pending=1, overflow=0.
   - Second event with clr=0 -> overflow[0]=1.
   - clr[0]=1 for one clock -> pending=0, overflow=0, irq=0.
5. Mode off: mode=8'h00, toggle all inputs slowly -> filt follows with 5-clock latency; pulse, pending and irq stay 0.
6. Reset mid-operation: drop anrst while cnt is non-zero and pending=4'hF -> all outputs 0 asynchronously.
   - Release with in=4'hF and mode=8'h55 -> pulse=4'hF after 5 clocks, then pending=4'hF.
